// File: rtl/keyboard_axil_fifo.sv
// PS/2 keyboard receiver with a scancode FIFO behind an AXI4-Lite slave.
// Map: 0x0 DATA (pop on read), 0x4 STATUS (W1C sticky bits), 0x8 CTRL, 0xC SCRATCH.
module keyboard_axil_fifo #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH         = 16,
  parameter int FILTER_LEN         = 8,
  parameter int TIMEOUT            = 100000
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  input  logic                              ps2_clk,
  input  logic                              ps2_data,
  output logic                              irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int NB = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} rx_state_t;

  // Count field is 8 bits wide; clamp instead of wrapping for the 256-deep case.
  function automatic logic [7:0] sat8(input logic [CW-1:0] v);
    return (v > CW'(255)) ? 8'hFF : 8'(v);
  endfunction

  // Sticky flag update: a set in the same cycle as a clear wins.
  function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
    return set | (cur & ~clr);
  endfunction

  logic clk_s1, clk_s2, dat_s1, dat_s2;
  logic clk_flt, flt_flip, flt_fall;
  logic [FW-1:0] flt_cnt;

  rx_state_t state, state_next;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [9:0]    frame;
  logic          par_ok, stop_ok;
  logic          rx_push, rx_perr, rx_ferr;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          fifo_empty, fifo_full, do_push, do_pop, ovf_set;
  logic [7:0]    head;

  logic          rx_en, irq_en, ovf, perr, ferr;
  logic [C_S_AXI_DATA_WIDTH-1:0] scratch, rd_mux;
  logic [1:0]    wr_sel, rd_sel;
  logic          wr_en, rd_en, rd_pop_pend;
  logic          w1c_ovf, w1c_perr, w1c_ferr;
  logic          unused;

  assign unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Two-flop synchronisers for the asynchronous PS/2 lines (idle high).
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign flt_flip = (clk_s2 != clk_flt) && (flt_cnt == FW'(FILTER_LEN - 1));
  assign flt_fall = flt_flip && clk_flt;

  // Glitch filter: the clock level flips after FILTER_LEN consecutive differing samples.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      clk_flt <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_s2 == clk_flt) begin
      flt_cnt <= '0;
    end else if (flt_flip) begin
      clk_flt <= clk_s2;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + FW'(1);
    end
  end

  // Frame layout after shifting: [7:0] data, [8] parity, [9] stop.
  assign par_ok  = ^frame[8:0];
  assign stop_ok = frame[9];

  // Receive FSM state register.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) state <= IDLE;
    else                  state <= state_next;
  end

  // Receive FSM next-state and per-frame result strobes.
  always_comb begin
    state_next = state;
    rx_push    = 1'b0;
    rx_perr    = 1'b0;
    rx_ferr    = 1'b0;
    unique case (state)
      IDLE: if (flt_fall && !dat_s2) state_next = SHIFT;
      SHIFT: begin
        if (flt_fall) begin
          if (bit_cnt == 4'd9) state_next = CHECK;
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          state_next = IDLE;
          rx_ferr    = 1'b1;
        end
      end
      CHECK: begin
        state_next = IDLE;
        rx_perr    = ~par_ok;
        rx_ferr    = ~stop_ok;
        rx_push    = par_ok & stop_ok & rx_en;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit counter and inter-edge timeout counter.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      bit_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      if (state != SHIFT)  bit_cnt <= '0;
      else if (flt_fall)   bit_cnt <= bit_cnt + 4'd1;
      if (state == SHIFT && !flt_fall) to_cnt <= to_cnt + TW'(1);
      else                             to_cnt <= '0;
    end
  end

  // Shift register, LSB first: each new bit enters at the top.
  always_ff @(posedge s00_axi_aclk) begin
    if (state == SHIFT && flt_fall) frame <= {dat_s2, frame[9:1]};
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign do_push    = rx_push & ~fifo_full;
  assign ovf_set    = rx_push & fifo_full;
  assign head       = fifo_empty ? 8'h00 : mem[rptr];

  // FIFO storage.
  always_ff @(posedge s00_axi_aclk) begin
    if (do_push) mem[wptr] <= frame[7:0];
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign s00_axi_wready = s00_axi_awready;
  assign s00_axi_bresp  = 2'b00;
  assign s00_axi_rresp  = 2'b00;
  assign wr_en  = s00_axi_awready & s00_axi_awvalid & s00_axi_wvalid;
  assign wr_sel = s00_axi_awaddr[3:2];
  assign rd_en  = s00_axi_arready & s00_axi_arvalid;
  assign rd_sel = s00_axi_araddr[3:2];

  // Write channel: one-cycle address/data accept, response held until bready.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_awready <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
    end else begin
      s00_axi_awready <= ~s00_axi_awready & s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid;
      if (wr_en)               s00_axi_bvalid <= 1'b1;
      else if (s00_axi_bready) s00_axi_bvalid <= 1'b0;
    end
  end

  assign w1c_ovf  = wr_en && wr_sel == 2'd1 && s00_axi_wstrb[0] && s00_axi_wdata[2];
  assign w1c_perr = wr_en && wr_sel == 2'd1 && s00_axi_wstrb[0] && s00_axi_wdata[3];
  assign w1c_ferr = wr_en && wr_sel == 2'd1 && s00_axi_wstrb[0] && s00_axi_wdata[4];

  // Control, scratch and sticky status registers.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rx_en   <= 1'b1;
      irq_en  <= 1'b0;
      scratch <= '0;
      ovf     <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      if (wr_en && wr_sel == 2'd2 && s00_axi_wstrb[0]) begin
        rx_en  <= s00_axi_wdata[0];
        irq_en <= s00_axi_wdata[1];
      end
      for (int i = 0; i < NB; i++) begin
        if (wr_en && wr_sel == 2'd3 && s00_axi_wstrb[i]) scratch[i*8 +: 8] <= s00_axi_wdata[i*8 +: 8];
      end
      ovf  <= sticky_next(ovf,  ovf_set, w1c_ovf);
      perr <= sticky_next(perr, rx_perr, w1c_perr);
      ferr <= sticky_next(ferr, rx_ferr, w1c_ferr);
    end
  end

  // Read data selection.
  always_comb begin
    rd_mux = '0;
    unique case (rd_sel)
      2'd0: rd_mux[7:0] = head;
      2'd1: begin
        rd_mux[0]    = fifo_empty;
        rd_mux[1]    = fifo_full;
        rd_mux[2]    = ovf;
        rd_mux[3]    = perr;
        rd_mux[4]    = ferr;
        rd_mux[15:8] = sat8(count);
      end
      2'd2: rd_mux[1:0] = {irq_en, rx_en};
      default: rd_mux = scratch;
    endcase
  end

  // A DATA pop is decided at capture time so a byte arriving later is never lost.
  assign do_pop = s00_axi_rvalid & s00_axi_rready & rd_pop_pend;

  // Read channel: capture on address accept, hold data until rready.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
      rd_pop_pend     <= 1'b0;
    end else begin
      s00_axi_arready <= ~s00_axi_arready & s00_axi_arvalid & ~s00_axi_rvalid;
      if (rd_en) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_mux;
        rd_pop_pend    <= (rd_sel == 2'd0) && !fifo_empty;
      end else if (s00_axi_rvalid && s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
        rd_pop_pend    <= 1'b0;
      end
    end
  end

  // Registered level interrupt.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) irq <= 1'b0;
    else                  irq <= irq_en & (~fifo_empty | ovf);
  end

endmodule

// File: tb/tb_keyboard_axil_fifo.sv
// Self-checking bench for keyboard_axil_fifo: register vector table plus PS/2 frame sequences.
module tb_keyboard_axil_fifo;
  localparam int DEPTH = 16;
  localparam int FLT   = 8;
  localparam int TO    = 300;
  localparam int HALF  = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic        ps2_clk, ps2_data, irq;

  int checks = 0;
  int fails  = 0;
  logic [7:0] exp_q[$];
  logic       last_bvalid;
  logic [1:0] last_bresp, last_rresp;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;
  localparam int NV = 13;
  vec_t tbl[NV];

  always #5 clk = ~clk;

  keyboard_axil_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLT), .TIMEOUT(TO)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic aw_handshake(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    tick(1);
    while (!awready && n < 50) begin tick(1); n++; end
    if (!awready) check("awready_timeout", 32'(awready), 32'h1);
    tick(1);
    awvalid = 1'b0; wvalid = 1'b0;
    last_bvalid = bvalid;
    last_bresp  = bresp;
  endtask

  task automatic ar_handshake(input logic [3:0] a);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    tick(1);
    while (!arready && n < 50) begin tick(1); n++; end
    if (!arready) check("arready_timeout", 32'(arready), 32'h1);
    tick(1);
    arvalid = 1'b0;
    last_rresp = rresp;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    aw_handshake(a, d, s);
    bready = 1'b1;
    tick(1);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    ar_handshake(a);
    d = rdata;
    rready = 1'b1;
    tick(1);
    rready = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    axi_read(a, v);
    check(name, v, exp);
  endtask

  task automatic read_data_sb(input string name);
    logic [31:0] v, e;
    axi_read(4'h0, v);
    e = (exp_q.size() == 0) ? 32'h0 : {24'h0, exp_q.pop_front()};
    check(name, v, e);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic ps2_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(stop);
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_ctl"}, {24'h0, awready, wready, bvalid, bresp, arready, rvalid, irq},
          32'h0);
    check({name, "_rdata_resp"}, rdata | {30'h0, rresp}, 32'h0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, d0;
    logic        stable;

    rst_n = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;
    arvalid = 1'b0; rready = 1'b0;
    ps2_clk = 1'b1; ps2_data = 1'b1;

    tbl[0]  = '{1'b1, 4'hC, 32'hA5A55A5A, 4'b0011, 32'h0};
    tbl[1]  = '{1'b0, 4'hC, 32'h0,        4'b0000, 32'h00005A5A};
    tbl[2]  = '{1'b1, 4'h8, 32'h00000003, 4'b1111, 32'h0};
    tbl[3]  = '{1'b0, 4'h8, 32'h0,        4'b0000, 32'h00000003};
    tbl[4]  = '{1'b1, 4'hC, 32'h12345678, 4'b1100, 32'h0};
    tbl[5]  = '{1'b0, 4'hC, 32'h0,        4'b0000, 32'h12345A5A};
    tbl[6]  = '{1'b1, 4'h8, 32'hFFFFFFFC, 4'b1111, 32'h0};
    tbl[7]  = '{1'b0, 4'h8, 32'h0,        4'b0000, 32'h00000000};
    tbl[8]  = '{1'b1, 4'h8, 32'h00000001, 4'b0001, 32'h0};
    tbl[9]  = '{1'b1, 4'h0, 32'h000000FF, 4'b1111, 32'h0};
    tbl[10] = '{1'b0, 4'h0, 32'h0,        4'b0000, 32'h00000000};
    tbl[11] = '{1'b0, 4'h4, 32'h0,        4'b0000, 32'h00000001};
    tbl[12] = '{1'b0, 4'h8, 32'h0,        4'b0000, 32'h00000001};

    // reset state
    tick(3);
    check_reset_outs("reset");
    rst_n = 1'b1;
    tick(3);
    check_reg("rst_status", 4'h4, 32'h1);
    check_reg("rst_ctrl", 4'h8, 32'h1);
    check_reg("rst_scratch", 4'hC, 32'h0);

    // register vectors
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
        check($sformatf("vec%0d_bresp", i), {29'h0, last_bvalid, last_bresp}, 32'h4);
      end else begin
        axi_read(tbl[i].addr, v);
        check($sformatf("vec%0d_rdata", i), v, tbl[i].exp);
        check($sformatf("vec%0d_rresp", i), {30'h0, last_rresp}, 32'h0);
      end
    end

    // single frame
    ps2_frame(8'h1C, 1'b0, 1'b1);
    exp_q.push_back(8'h1C);
    check_reg("one_frame_status", 4'h4, 32'h00000100);
    read_data_sb("one_frame_data");
    check_reg("one_frame_empty", 4'h4, 32'h00000001);

    // interrupt
    axi_write(4'h8, 32'h3, 4'hF);
    tick(2);
    check("irq_empty", 32'(irq), 32'h0);
    ps2_frame(8'h5A, 1'b0, 1'b1);
    exp_q.push_back(8'h5A);
    tick(2);
    check("irq_pending", 32'(irq), 32'h1);
    read_data_sb("irq_data");
    check("irq_hold_one_cycle", 32'(irq), 32'h1);
    tick(1);
    check("irq_cleared", 32'(irq), 32'h0);
    axi_write(4'h8, 32'h1, 4'hF);

    // fill past full
    for (int i = 0; i <= DEPTH; i++) begin
      ps2_frame(8'(i * 13 + 5), 1'b0, 1'b1);
      if (i < DEPTH) exp_q.push_back(8'(i * 13 + 5));
    end
    check_reg("full_status", 4'h4, {16'h0, 8'(DEPTH), 8'h06});
    axi_write(4'h4, 32'h4, 4'h1);
    check_reg("ovf_w1c", 4'h4, {16'h0, 8'(DEPTH), 8'h02});
    for (int i = 0; i < DEPTH; i++) read_data_sb($sformatf("drain%0d", i));
    check_reg("drained_status", 4'h4, 32'h1);
    read_data_sb("empty_data_read");

    // error frames
    ps2_frame(8'h33, 1'b1, 1'b1);
    check_reg("parity_err", 4'h4, 32'h00000009);
    axi_write(4'h4, 32'h8, 4'h1);
    ps2_frame(8'h44, 1'b0, 1'b0);
    check_reg("frame_err_stop", 4'h4, 32'h00000011);
    axi_write(4'h4, 32'h10, 4'h1);
    check_reg("frame_err_clr", 4'h4, 32'h00000001);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_data = 1'b1;
    tick(TO + 50);
    check_reg("timeout_err", 4'h4, 32'h00000011);
    axi_write(4'h4, 32'h10, 4'h1);
    ps2_frame(8'h3C, 1'b0, 1'b1);
    exp_q.push_back(8'h3C);
    check_reg("after_timeout_status", 4'h4, 32'h00000100);
    read_data_sb("after_timeout_data");

    // receive disabled
    ps2_frame(8'h42, 1'b0, 1'b1);
    exp_q.push_back(8'h42);
    axi_write(4'h8, 32'h0, 4'hF);
    ps2_frame(8'h77, 1'b0, 1'b1);
    check_reg("rx_dis_status", 4'h4, 32'h00000100);
    axi_write(4'h8, 32'h1, 4'hF);
    read_data_sb("rx_dis_data");

    // read response stall
    axi_write(4'hC, 32'hDEADBEEF, 4'hF);
    ar_handshake(4'hC);
    d0 = rdata;
    stable = rvalid;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (!rvalid || rdata !== d0) stable = 1'b0;
    end
    check("rstall_stable", 32'(stable), 32'h1);
    check("rstall_data", d0, 32'hDEADBEEF);
    rready = 1'b1; tick(1); rready = 1'b0;
    check("rstall_release", 32'(rvalid), 32'h0);

    // write response stall
    aw_handshake(4'hC, 32'h0BADF00D, 4'hF);
    stable = bvalid;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (!bvalid || bresp !== 2'b00) stable = 1'b0;
    end
    check("bstall_stable", 32'(stable), 32'h1);
    bready = 1'b1; tick(1); bready = 1'b0;
    check("bstall_release", 32'(bvalid), 32'h0);
    check_reg("bstall_scratch", 4'hC, 32'h0BADF00D);

    // reset mid-frame with pending data, irq and a sticky bit
    axi_write(4'h8, 32'h3, 4'hF);
    ps2_frame(8'hAB, 1'b0, 1'b1);
    ps2_frame(8'h55, 1'b1, 1'b1);
    tick(2);
    check("pre_reset_irq", 32'(irq), 32'h1);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    tick(HALF);
    rst_n = 1'b0;
    tick(1);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    tick(2);
    check_reset_outs("midframe_reset");
    exp_q.delete();
    rst_n = 1'b1;
    tick(4 * HALF);
    check_reg("post_reset_status", 4'h4, 32'h1);
    check_reg("post_reset_ctrl", 4'h8, 32'h1);
    check_reg("post_reset_scratch", 4'hC, 32'h0);
    ps2_frame(8'h99, 1'b0, 1'b1);
    exp_q.push_back(8'h99);
    check_reg("post_reset_frame_status", 4'h4, 32'h00000100);
    read_data_sb("post_reset_frame_data");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
